wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter between the functional units and the ROB completion ports.
- NUM_REQ functional-unit requesters compete for NUM_PORTS FU_ROB_PACKET slots per cycle.
- Grants use a rotating round-robin pointer. Each requester has a one-entry holding buffer, so a losing completion is never dropped.
- Output slots are registered and drive the ROB fu_rob_packet input. A ROB squash flushes every in-flight completion.

Parameters:
- NUM_REQ, 8, number of FU writeback requesters.
- NUM_PORTS, `FU_ROB_PACKET_SZ, number of ROB completion slots per cycle (1 <= NUM_PORTS <= NUM_REQ).
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  ROB mispredict squash; flushes the arbiter.
- req_valid  in  NUM_REQ  per-FU completion valid.
- req_packet  in  FU_ROB_PACKET[NUM_REQ]  per-FU completion (executed, robn, branch_taken, target_addr).
- req_ready  out  NUM_REQ  FU may present a new completion this cycle.
- fu_rob_packet  out  FU_ROB_PACKET[NUM_PORTS]  registered completions to the ROB.
- pending_cnt  out  $clog2(NUM_REQ+1)  number of valid holding buffers.
- rr_ptr_out  out  PTR_W  current round-robin pointer, for debug and verification.

Behaviour:
- State:
  - hold_valid[NUM_REQ] and hold_pkt[NUM_REQ].
  - rr_ptr.
  - out_pkt[NUM_PORTS].
- Reset (synchronous, dominates squash):
  - hold_valid = 0 and rr_ptr = 0.
  - All out_pkt all-zero, so executed = 0.
  - req_ready = all 1s; pending_cnt = 0.
- req_ready[i] = ~hold_valid[i]. It depends only on registered state, with no combinational path from req_valid or grant.
- Acceptance: a request is accepted when req_valid[i] & req_ready[i].
- req_valid[i] while hold_valid[i] = 1 is protocol-illegal. The arbiter ignores it and the bench asserts on it.
- Candidate set:
  - cand[i] = hold_valid[i] | accepted[i].
  - cand_pkt[i] = hold_valid[i] ? hold_pkt[i] : req_packet[i].
- Grant selection:
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ, one full lap.
  - Grant the first NUM_PORTS candidates.
  - The k-th grant in scan order fills slot k.
  - Unfilled slots are all-zero.
- Latency:
  - A completion granted in cycle t appears on fu_rob_packet in cycle t+1 and is valid for exactly one cycle.
  - Minimum latency is 1 cycle; maximum is 1 + ceil(NUM_REQ/NUM_PORTS) cycles.
- Holding buffers:
  - An accepted but ungranted request loads hold_pkt[i] and sets hold_valid[i].
  - A granted holding buffer clears next cycle.
  - A buffer that is held and not granted stays unchanged.
- Pointer update:
  - If there is at least one grant, rr_ptr <= (last granted index + 1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
  - With no grants, rr_ptr holds.
- Fairness: every valid holding buffer is granted within ceil(NUM_REQ/NUM_PORTS) cycles of being set.
- pending_cnt is the popcount of registered hold_valid.
- Squash (without reset):
  - Next cycle: all out_pkt all-zero and hold_valid = 0.
  - Same-cycle req_valid is discarded.
  - rr_ptr is retained.
- Grant counts:
  - Fewer than NUM_PORTS candidates: all granted in the same cycle, none held.
  - Zero candidates: outputs zero next cycle and rr_ptr holds.

Test Plan (NUM_REQ=8, NUM_PORTS=3):
- Reset: assert reset 2 cycles with req_valid = 0xFF.
  - Next cycle: every slot executed = 0, req_ready = 0xFF, pending_cnt = 0, rr_ptr_out = 0.
- Sparse: rr_ptr = 0, req_valid = 0x22 (FU1 robn = 4, FU5 robn = 9).
  - Next cycle: slot0.robn = 4, slot1.robn = 9, slot2 all-zero; rr_ptr = 6; pending_cnt = 0.
- Overload: rr_ptr = 0, req_valid = 0xFF (robn = FU index).
  - Cycle t+1: slots robn 0,1,2; req_ready = 0x07; pending_cnt = 5; rr_ptr = 3.
  - Cycle t+2: slots robn 3,4,5, from holds.
  - Cycle t+3: slots robn 6,7; nothing lost.
- Wrap-around: rr_ptr = 6, req_valid = 0xC5 (FUs 0, 2, 6, 7).
  - Next cycle: slots hold FU6, FU7, FU0 in that order; FU2 held; rr_ptr = 1.
  - Cycle after: FU2 in slot0.
- Squash: after the overload cycle (pending_cnt = 5), assert squash with req_valid = 0x07.
  - Next cycle: all slots executed = 0, pending_cnt = 0, req_ready = 0xFF, rr_ptr unchanged (3).
- Reset mid-operation: pending_cnt = 4 and rr_ptr = 5, assert reset together with squash.
  - Next cycle: state equals the reset state, with rr_ptr = 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_REQ functional units compete for NUM_PORTS ROB
// completion slots per cycle. Round-robin grants with a one-entry holding
// buffer per requester so losing completions wait instead of being dropped.

package wb_arbiter_pkg;
    localparam int ROBN_W           = 5;
    localparam int FU_ROB_PACKET_SZ = 3;

    typedef struct packed {
        logic              executed;
        logic [ROBN_W-1:0] robn;
        logic              branch_taken;
        logic [31:0]       target_addr;
    } fu_rob_packet_t;
endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 8,
    parameter int NUM_PORTS = FU_ROB_PACKET_SZ,
    parameter int PTR_W     = $clog2(NUM_REQ)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  fu_rob_packet_t [NUM_REQ-1:0]        req_packet,
    output logic [NUM_REQ-1:0]                  req_ready,
    output fu_rob_packet_t [NUM_PORTS-1:0]      fu_rob_packet,
    output logic [$clog2(NUM_REQ+1)-1:0]        pending_cnt,
    output logic [PTR_W-1:0]                    rr_ptr_out
);

    localparam int CNT_W  = $clog2(NUM_REQ+1);
    localparam int SLOT_W = $clog2(NUM_PORTS+1);

    logic [NUM_REQ-1:0]             hold_valid;
    fu_rob_packet_t [NUM_REQ-1:0]   hold_pkt;
    logic [PTR_W-1:0]               rr_ptr;
    fu_rob_packet_t [NUM_PORTS-1:0] out_pkt;

    logic [NUM_REQ-1:0]             accepted;
    logic [NUM_REQ-1:0]             cand;
    fu_rob_packet_t [NUM_REQ-1:0]   cand_pkt;
    logic [NUM_REQ-1:0]             granted;
    fu_rob_packet_t [NUM_PORTS-1:0] slot_pkt;
    logic                           any_grant;
    logic [PTR_W-1:0]               last_idx;
    logic [PTR_W-1:0]               next_ptr;
    logic [CNT_W-1:0]               pend;

    // Ready comes purely from registered hold state so FUs see no comb path.
    assign req_ready     = ~hold_valid;
    assign accepted      = req_valid & ~hold_valid;
    assign cand          = hold_valid | accepted;
    assign fu_rob_packet = out_pkt;
    assign rr_ptr_out    = rr_ptr;
    assign pending_cnt   = pend;

    // A held completion takes priority over the live FU bus for that index.
    always_comb begin
        cand_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_pkt[i] = hold_valid[i] ? hold_pkt[i] : req_packet[i];
        end
    end

    // Scan one lap from rr_ptr, filling slots in scan order with the first candidates.
    always_comb begin
        logic [PTR_W:0]  sum;
        logic [PTR_W-1:0] idx;
        logic [SLOT_W-1:0] gcnt;
        granted   = '0;
        slot_pkt  = '0;
        any_grant = 1'b0;
        last_idx  = rr_ptr;
        gcnt      = '0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (cand[idx] && (gcnt < SLOT_W'(NUM_PORTS))) begin
                slot_pkt[gcnt] = cand_pkt[idx];
                granted[idx]   = 1'b1;
                any_grant      = 1'b1;
                last_idx       = idx;
                gcnt           = gcnt + SLOT_W'(1);
            end
        end
    end

    // Pointer moves just past the last winner so it loses priority next cycle.
    always_comb begin
        next_ptr = rr_ptr;
        if (any_grant) begin
            if (last_idx == PTR_W'(NUM_REQ-1)) begin
                next_ptr = '0;
            end else begin
                next_ptr = last_idx + PTR_W'(1);
            end
        end
    end

    // Popcount of the registered holding buffers.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend = pend + CNT_W'(hold_valid[i]);
        end
    end

    // State update: reset beats squash; squash flushes everything but keeps the pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= '0;
            hold_pkt   <= '0;
            rr_ptr     <= '0;
            out_pkt    <= '0;
        end else if (squash) begin
            hold_valid <= '0;
            out_pkt    <= '0;
        end else begin
            out_pkt <= slot_pkt;
            rr_ptr  <= next_ptr;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accepted[i] && !granted[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_pkt[i]   <= req_packet[i];
                end else if (hold_valid[i] && granted[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (NUM_REQ=8, NUM_PORTS=3): a vector table
// drives one cycle per row, the expected post-edge state is queued and then
// popped and compared after the edge; a hand-written latency check follows.

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NR = 8;
    localparam int NP = 3;

    logic                     clock;
    logic                     reset;
    logic                     squash;
    logic [NR-1:0]            req_valid;
    fu_rob_packet_t [NR-1:0]  req_packet;
    logic [NR-1:0]            req_ready;
    fu_rob_packet_t [NP-1:0]  fu_rob_packet;
    logic [3:0]               pending_cnt;
    logic [2:0]               rr_ptr_out;

    typedef struct {
        logic             rst;
        logic             sq;
        logic [NR-1:0]    rv;
        logic [NR-1:0][4:0] robn;
        logic [NP-1:0]    exp_vld;
        logic [NP-1:0][4:0] exp_robn;
        logic [NR-1:0]    exp_ready;
        logic [3:0]       exp_pend;
        logic [2:0]       exp_rr;
    } vec_t;

    typedef struct {
        fu_rob_packet_t [NP-1:0] slots;
        logic [NR-1:0]           ready;
        logic [3:0]              pend;
        logic [2:0]              rr;
        int                      row;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    wb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP)) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .req_valid    (req_valid),
        .req_packet   (req_packet),
        .req_ready    (req_ready),
        .fu_rob_packet(fu_rob_packet),
        .pending_cnt  (pending_cnt),
        .rr_ptr_out   (rr_ptr_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every completion field is derived from its robn so a whole-packet compare catches swaps.
    function automatic fu_rob_packet_t mk_pkt(input logic [4:0] robn);
        fu_rob_packet_t p;
        p.executed     = 1'b1;
        p.robn         = robn;
        p.branch_taken = robn[0];
        p.target_addr  = 32'h4000_0000 | {25'd0, robn, 2'b00};
        return p;
    endfunction

    function automatic vec_t mk_vec(input logic rst, input logic sq, input logic [7:0] rv,
                                    input logic [7:0][4:0] robn, input logic [2:0] vld,
                                    input logic [2:0][4:0] er, input logic [7:0] rdy,
                                    input logic [3:0] pend, input logic [2:0] rr);
        vec_t v;
        v.rst = rst; v.sq = sq; v.rv = rv; v.robn = robn;
        v.exp_vld = vld; v.exp_robn = er; v.exp_ready = rdy;
        v.exp_pend = pend; v.exp_rr = rr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input int row);
        exp_t e;
        reset  = v.rst;
        squash = v.sq;
        req_valid = v.rv;
        for (int i = 0; i < NR; i++) begin
            req_packet[i] = mk_pkt(v.robn[i]);
        end
        for (int s = 0; s < NP; s++) begin
            e.slots[s] = v.exp_vld[s] ? mk_pkt(v.exp_robn[s]) : '0;
        end
        e.ready = v.exp_ready;
        e.pend  = v.exp_pend;
        e.rr    = v.exp_rr;
        e.row   = row;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard_empty: actual 0 entries, required >= 1");
            return;
        end
        e = sb.pop_front();
        for (int s = 0; s < NP; s++) begin
            checks++;
            if (fu_rob_packet[s] !== e.slots[s]) begin
                fails++;
                $display("[TB] FAIL row%0d_slot%0d: actual %h required %h", e.row, s, fu_rob_packet[s], e.slots[s]);
            end
        end
        checks++;
        if (req_ready !== e.ready) begin
            fails++;
            $display("[TB] FAIL row%0d_req_ready: actual %h required %h", e.row, req_ready, e.ready);
        end
        checks++;
        if (pending_cnt !== e.pend) begin
            fails++;
            $display("[TB] FAIL row%0d_pending_cnt: actual %0d required %0d", e.row, pending_cnt, e.pend);
        end
        checks++;
        if (rr_ptr_out !== e.rr) begin
            fails++;
            $display("[TB] FAIL row%0d_rr_ptr: actual %0d required %0d", e.row, rr_ptr_out, e.rr);
        end
    endtask

    // Protocol check: an FU must never present a completion while its buffer is full.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            if ((req_valid & ~req_ready) != '0) begin
                fails++;
                $display("[TB] FAIL protocol_valid_while_held: actual %h required 00", req_valid & ~req_ready);
            end
        end
    end

    initial begin
        logic [7:0][4:0] id_map;
        logic [7:0][4:0] map10;
        logic [7:0][4:0] sparse_map;
        int found_cycle;

        for (int i = 0; i < NR; i++) begin
            id_map[i] = 5'(i);
            map10[i]  = 5'(i + 10);
        end
        sparse_map    = id_map;
        sparse_map[1] = 5'd4;
        sparse_map[5] = 5'd9;

        //                 rst   sq    rv     robn        vld     {s2,s1,s0}           ready  pend rr
        vecs.push_back(mk_vec(1'b1, 1'b0, 8'hFF, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 0 reset
        vecs.push_back(mk_vec(1'b1, 1'b0, 8'hFF, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 1 reset
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h00, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 2 idle
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h22, sparse_map, 3'b011, {5'd0, 5'd9, 5'd4},  8'hFF, 4'd0, 3'd6)); // 3 sparse
        vecs.push_back(mk_vec(1'b1, 1'b0, 8'h00, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 4 reset
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'hFF, id_map,     3'b111, {5'd2, 5'd1, 5'd0},  8'h07, 4'd5, 3'd3)); // 5 overload
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h00, id_map,     3'b111, {5'd5, 5'd4, 5'd3},  8'h3F, 4'd2, 3'd6)); // 6 drain
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h00, id_map,     3'b011, {5'd0, 5'd7, 5'd6},  8'hFF, 4'd0, 3'd0)); // 7 drain, wrap
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h20, id_map,     3'b001, {5'd0, 5'd0, 5'd5},  8'hFF, 4'd0, 3'd6)); // 8 move ptr
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'hC5, map10,      3'b111, {5'd10, 5'd17, 5'd16}, 8'hFB, 4'd1, 3'd1)); // 9 wrap-around
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h00, id_map,     3'b001, {5'd0, 5'd0, 5'd12}, 8'hFF, 4'd0, 3'd3)); // 10 FU2 from hold
        vecs.push_back(mk_vec(1'b1, 1'b0, 8'h00, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 11 reset
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'hFF, id_map,     3'b111, {5'd2, 5'd1, 5'd0},  8'h07, 4'd5, 3'd3)); // 12 overload
        vecs.push_back(mk_vec(1'b0, 1'b1, 8'h07, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd3)); // 13 squash
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h00, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd3)); // 14 flushed
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h02, id_map,     3'b001, {5'd0, 5'd0, 5'd1},  8'hFF, 4'd0, 3'd2)); // 15 ptr to 2
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'hFD, id_map,     3'b111, {5'd4, 5'd3, 5'd2},  8'h1E, 4'd4, 3'd5)); // 16 pend 4, rr 5
        vecs.push_back(mk_vec(1'b1, 1'b1, 8'h1E, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 17 reset+squash
        vecs.push_back(mk_vec(1'b0, 1'b0, 8'h00, id_map,     3'b000, {5'd0, 5'd0, 5'd0},  8'hFF, 4'd0, 3'd0)); // 18 idle

        reset      = 1'b1;
        squash     = 1'b0;
        req_valid  = '0;
        req_packet = '0;

        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clock);
            #1;
            if (r > 0) checkOutput();
            applyStimulus(vecs[r], r);
        end
        @(posedge clock);
        #1;
        checkOutput();

        // Hand-written sequence: single completion must appear exactly one cycle later, for one cycle.
        req_valid     = 8'h10;
        req_packet[4] = mk_pkt(5'd30);
        found_cycle   = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock);
            #1;
            req_valid = '0;
            if (found_cycle == 0 && fu_rob_packet[0] === mk_pkt(5'd30)) begin
                found_cycle = c;
                checks++;
                if (rr_ptr_out !== 3'd5) begin
                    fails++;
                    $display("[TB] FAIL latency_rr_ptr: actual %0d required 5", rr_ptr_out);
                end
            end
        end
        checks++;
        if (found_cycle != 1) begin
            fails++;
            $display("[TB] FAIL latency_single: actual cycle %0d required cycle 1 (0 = never within bound)", found_cycle);
        end
        checks++;
        if (fu_rob_packet[0].executed !== 1'b0) begin
            fails++;
            $display("[TB] FAIL one_cycle_valid: actual executed %b required 0", fu_rob_packet[0].executed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
